dest_gen_pipe: RTL and testbench

//  Registered, handshaked successor of the combinational destination generator in Exe0/Int0.
//  Per accepted token it decides T/F branch, next node/LR/uni-opr and copy/terminate.

---
 rtl/dgp_pkg.sv | 56 +++++
 rtl/dgp_if.sv | 53 +++++
 rtl/dgp_decode.sv | 73 +++++++
 rtl/dest_gen_pipe.sv | 180 ++++++++++++++++++
 tb/tb_dest_gen_pipe.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dgp_pkg.sv
// Shared types and decode helpers for the destination generator pipeline.
package dgp_pkg;

  // Output sequencer states: idle, presenting the T beat, presenting the F beat.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT_T = 2'd1,
    ST_EMIT_F = 2'd2
  } state_e;

  // Branch condition codes (cc).
  localparam logic [1:0] CC_ALWAYS = 2'b00;
  localparam logic [1:0] CC_RC0    = 2'b01;
  localparam logic [1:0] CC_RC1    = 2'b10;
  localparam logic [1:0] CC_ALL    = 2'b11;

  // Copy-generation types (cc_type[1:0]).
  localparam logic [1:0] CG_ALL_CC = 2'b00;
  localparam logic [1:0] CG_CC_10  = 2'b10;

  // Per-beat flags carried alongside the node address.
  typedef struct packed {
    logic uni;
    logic lr;
    logic ovf;
  } beat_flags_t;

  // Branch-taken test: does the condition code select the T path.
  function automatic logic bt(input logic [1:0] cc, input logic [1:0] rc);
    case (cc)
      CC_RC0:  bt = rc[0];
      CC_RC1:  bt = rc[1];
      default: bt = 1'b1;
    endcase
  endfunction

  // Copy generation: does a jump fan out into both T and F beats.
  function automatic logic cg(input logic [1:0] cg_type, input logic [1:0] cc);
    case (cg_type)
      CG_ALL_CC: cg = &cc;
      CG_CC_10:  cg = (cc == 2'b10);
      default:   cg = 1'b0;
    endcase
  endfunction

  // Gate pass test: a gate token survives only when this is true.
  function automatic logic gg(input logic [1:0] cc, input logic [1:0] rc);
    case (cc)
      2'b00:   gg = rc[1];
      2'b01:   gg = ~rc[1];
      2'b10:   gg = ~rc[1] & rc[0];
      default: gg = ~rc[1] & ~rc[0];
    endcase
  endfunction

endpackage

// File: rtl/dgp_if.sv
// Token-in / beat-out handshake bundle of the destination generator.
interface dgp_if #(
  parameter int NODE_W = 16,
  parameter int OFS_W  = 8
) ();
  logic              in_valid_i_dgp;
  logic              in_ready_o_dgp;
  logic [NODE_W-1:0] node_i_dgp;
  logic [OFS_W-1:0]  t_dest_i_dgp;
  logic [OFS_W-1:0]  f_dest_i_dgp;
  logic              t_uni_opr_i_dgp;
  logic              t_lr_i_dgp;
  logic              f_uni_opr_i_dgp;
  logic              f_lr_i_dgp;
  logic [1:0]        cc_i_dgp;
  logic              rslt_jmp_i_dgp;
  logic [1:0]        rslt_cc_i_dgp;
  logic [2:0]        cc_type_i_dgp;
  logic              pe_out_i_dgp;
  logic              pe_lr_i_dgp;
  logic              jmp_dst_valid_i_dgp;
  logic [NODE_W:0]   jmp_dst_i_dgp;
  logic              gate_i_dgp;
  logic              out_valid_o_dgp;
  logic              out_ready_i_dgp;
  logic [NODE_W-1:0] out_node_o_dgp;
  logic              out_uni_opr_o_dgp;
  logic              out_lr_o_dgp;
  logic              out_path_o_dgp;
  logic              out_ovf_o_dgp;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid_i_dgp, node_i_dgp, t_dest_i_dgp, f_dest_i_dgp,
           t_uni_opr_i_dgp, t_lr_i_dgp, f_uni_opr_i_dgp, f_lr_i_dgp,
           cc_i_dgp, rslt_jmp_i_dgp, rslt_cc_i_dgp, cc_type_i_dgp,
           pe_out_i_dgp, pe_lr_i_dgp, jmp_dst_valid_i_dgp, jmp_dst_i_dgp,
           gate_i_dgp, out_ready_i_dgp,
    input  in_ready_o_dgp, out_valid_o_dgp, out_node_o_dgp,
           out_uni_opr_o_dgp, out_lr_o_dgp, out_path_o_dgp, out_ovf_o_dgp
  );

  // Destination generator side.
  modport slave (
    input  in_valid_i_dgp, node_i_dgp, t_dest_i_dgp, f_dest_i_dgp,
           t_uni_opr_i_dgp, t_lr_i_dgp, f_uni_opr_i_dgp, f_lr_i_dgp,
           cc_i_dgp, rslt_jmp_i_dgp, rslt_cc_i_dgp, cc_type_i_dgp,
           pe_out_i_dgp, pe_lr_i_dgp, jmp_dst_valid_i_dgp, jmp_dst_i_dgp,
           gate_i_dgp, out_ready_i_dgp,
    output in_ready_o_dgp, out_valid_o_dgp, out_node_o_dgp,
           out_uni_opr_o_dgp, out_lr_o_dgp, out_path_o_dgp, out_ovf_o_dgp
  );
endinterface

// File: rtl/dgp_decode.sv
// Pure combinational token decode: T/F beat contents, copy and terminate flags.
module dgp_decode
  import dgp_pkg::*;
#(
  parameter int NODE_W   = 16,
  parameter int OFS_W    = 8,
  parameter int OVF_MODE = 0
) (
  input  logic              jmp_i,
  input  logic              gate_i,
  input  logic [1:0]        cc_i,
  input  logic [1:0]        rc_i,
  input  logic [2:0]        cc_type_i,
  input  logic [NODE_W-1:0] node_i,
  input  logic [OFS_W-1:0]  t_dest_i,
  input  logic [OFS_W-1:0]  f_dest_i,
  input  logic              t_uni_i,
  input  logic              t_lr_i,
  input  logic              f_uni_i,
  input  logic              f_lr_i,
  input  logic              pe_out_i,
  input  logic              pe_lr_i,
  input  logic              jmp_dst_valid_i,
  input  logic [NODE_W:0]   jmp_dst_i,
  output logic [NODE_W-1:0] t_node_o,
  output beat_flags_t       t_flags_o,
  output logic [NODE_W-1:0] f_node_o,
  output beat_flags_t       f_flags_o,
  output logic              cp_o,
  output logic              term_o
);

  localparam int   EXT_W  = NODE_W + 1 - OFS_W;
  localparam logic OVF_EN = (OVF_MODE != 0);

  // The extra top bit of each sum is set exactly when the signed result
  // leaves [0, 2^NODE_W-1], so it doubles as the overflow flag.
  logic [NODE_W:0] t_sum;
  logic [NODE_W:0] f_sum;
  logic            tf;
  logic            sel;

  assign t_sum = {1'b0, node_i} + {{EXT_W{t_dest_i[OFS_W-1]}}, t_dest_i};
  assign f_sum = {1'b0, node_i} + {{EXT_W{f_dest_i[OFS_W-1]}}, f_dest_i};

  // Branch resolution and per-path beat contents.
  always_comb begin
    tf  = ~jmp_i | bt(cc_i, rc_i);
    sel = gate_i | tf;

    t_flags_o.uni = sel ? t_uni_i : f_uni_i;
    t_flags_o.lr  = sel ? (pe_out_i ? pe_lr_i : t_lr_i) : f_lr_i;
    if (jmp_dst_valid_i) begin
      t_node_o      = jmp_dst_i[NODE_W-1:0];
      t_flags_o.ovf = 1'b0;
    end else if (tf) begin
      t_node_o      = t_sum[NODE_W-1:0];
      t_flags_o.ovf = OVF_EN & t_sum[NODE_W];
    end else begin
      t_node_o      = f_sum[NODE_W-1:0];
      t_flags_o.ovf = OVF_EN & f_sum[NODE_W];
    end

    f_node_o      = f_sum[NODE_W-1:0];
    f_flags_o.uni = f_uni_i;
    f_flags_o.lr  = f_lr_i;
    f_flags_o.ovf = OVF_EN & f_sum[NODE_W];

    term_o = (jmp_i & (&cc_i) & (|cc_type_i[1:0])) | (gate_i & ~gg(cc_i, rc_i));
    cp_o   = ~term_o & ~gate_i & jmp_i & cg(cc_type_i[1:0], cc_i);
  end

endmodule

// File: rtl/dest_gen_pipe.sv
// Registered, handshaked destination generator: one or two output beats per
// surviving token, terminate pulses, and saturating event counters.
module dest_gen_pipe
  import dgp_pkg::*;
#(
  parameter int NODE_W   = 16,
  parameter int OFS_W    = 8,
  parameter int OVF_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i_dgp,
  input  logic             rst_i_dgp,
  dgp_if.slave             bus,
  output logic             term_o_dgp,
  input  logic             cnt_clr_i_dgp,
  output logic [CNT_W-1:0] tok_cnt_o_dgp,
  output logic [CNT_W-1:0] cp_cnt_o_dgp,
  output logic [CNT_W-1:0] term_cnt_o_dgp
);

  logic [NODE_W-1:0] dec_t_node, dec_f_node;
  beat_flags_t       dec_t_flags, dec_f_flags;
  logic              dec_cp, dec_term;

  dgp_decode #(.NODE_W(NODE_W), .OFS_W(OFS_W), .OVF_MODE(OVF_MODE)) u_decode (
    .jmp_i           (bus.rslt_jmp_i_dgp),
    .gate_i          (bus.gate_i_dgp),
    .cc_i            (bus.cc_i_dgp),
    .rc_i            (bus.rslt_cc_i_dgp),
    .cc_type_i       (bus.cc_type_i_dgp),
    .node_i          (bus.node_i_dgp),
    .t_dest_i        (bus.t_dest_i_dgp),
    .f_dest_i        (bus.f_dest_i_dgp),
    .t_uni_i         (bus.t_uni_opr_i_dgp),
    .t_lr_i          (bus.t_lr_i_dgp),
    .f_uni_i         (bus.f_uni_opr_i_dgp),
    .f_lr_i          (bus.f_lr_i_dgp),
    .pe_out_i        (bus.pe_out_i_dgp),
    .pe_lr_i         (bus.pe_lr_i_dgp),
    .jmp_dst_valid_i (bus.jmp_dst_valid_i_dgp),
    .jmp_dst_i       (bus.jmp_dst_i_dgp),
    .t_node_o        (dec_t_node),
    .t_flags_o       (dec_t_flags),
    .f_node_o        (dec_f_node),
    .f_flags_o       (dec_f_flags),
    .cp_o            (dec_cp),
    .term_o          (dec_term)
  );

  state_e            state_q, state_d;
  logic              rdy_en_q, rdy_en_d;
  logic              out_valid_q, out_valid_d;
  logic [NODE_W-1:0] out_node_q, out_node_d;
  beat_flags_t       out_flags_q, out_flags_d;
  logic              out_path_q, out_path_d;
  logic [NODE_W-1:0] f_node_q, f_node_d;
  beat_flags_t       f_flags_q, f_flags_d;
  logic              cp_q, cp_d;
  logic              term_q, term_d;
  logic [CNT_W-1:0]  tok_cnt_q, tok_cnt_d;
  logic [CNT_W-1:0]  cp_cnt_q, cp_cnt_d;
  logic [CNT_W-1:0]  term_cnt_q, term_cnt_d;

  logic last_beat, in_ready, accept, load;

  // The beat on the output is the token's last when no F beat is still owed.
  assign last_beat = ((state_q == ST_EMIT_T) & ~cp_q) | (state_q == ST_EMIT_F);
  // rdy_en_q keeps ready low through reset and for the first edge after it.
  assign in_ready  = rdy_en_q & ((state_q == ST_IDLE) | (bus.out_ready_i_dgp & last_beat));
  assign accept    = bus.in_valid_i_dgp & in_ready;
  assign load      = accept & ~dec_term;

  assign bus.in_ready_o_dgp    = in_ready;
  assign bus.out_valid_o_dgp   = out_valid_q;
  assign bus.out_node_o_dgp    = out_node_q;
  assign bus.out_uni_opr_o_dgp = out_flags_q.uni;
  assign bus.out_lr_o_dgp      = out_flags_q.lr;
  assign bus.out_ovf_o_dgp     = out_flags_q.ovf;
  assign bus.out_path_o_dgp    = out_path_q;
  assign term_o_dgp            = term_q;
  assign tok_cnt_o_dgp         = tok_cnt_q;
  assign cp_cnt_o_dgp          = cp_cnt_q;
  assign term_cnt_o_dgp        = term_cnt_q;

  // Next-state: advance past consumed beats, then load a newly accepted token.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred; comb blocks use blocking '=' only.
    state_d     = state_q;
    rdy_en_d    = 1'b1;
    out_node_d  = out_node_q;
    out_flags_d = out_flags_q;
    out_path_d  = out_path_q;
    f_node_d    = f_node_q;
    f_flags_d   = f_flags_q;
    cp_d        = cp_q;
    term_d      = accept & dec_term;

    if (bus.out_ready_i_dgp) begin
      case (state_q)
        ST_EMIT_T: begin
          if (cp_q) begin
            state_d     = ST_EMIT_F;
            out_node_d  = f_node_q;
            out_flags_d = f_flags_q;
            out_path_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EMIT_F: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // A load only happens when the output is free, so it never collides with
    // the T->F hand-over above.
    if (load) begin
      state_d     = ST_EMIT_T;
      out_node_d  = dec_t_node;
      out_flags_d = dec_t_flags;
      out_path_d  = 1'b0;
      f_node_d    = dec_f_node;
      f_flags_d   = dec_f_flags;
      cp_d        = dec_cp;
    end

    out_valid_d = (state_d != ST_IDLE);

    tok_cnt_d  = tok_cnt_q;
    cp_cnt_d   = cp_cnt_q;
    term_cnt_d = term_cnt_q;
    if (cnt_clr_i_dgp) begin
      tok_cnt_d  = '0;
      cp_cnt_d   = '0;
      term_cnt_d = '0;
    end else begin
      if (accept && tok_cnt_q != '1)                term_cnt_d = term_cnt_q;
      if (accept && tok_cnt_q != '1)                tok_cnt_d  = tok_cnt_q + 1'b1;
      if (load && dec_cp && cp_cnt_q != '1)         cp_cnt_d   = cp_cnt_q + 1'b1;
      if (accept && dec_term && term_cnt_q != '1)   term_cnt_d = term_cnt_q + 1'b1;
    end
  end

  // State and output registers; reset drops any pending F beat.
  always_ff @(posedge clk_i_dgp or posedge rst_i_dgp) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // its _d value from before the edge.
    if (rst_i_dgp) begin
      state_q     <= ST_IDLE;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_node_q  <= '0;
      out_flags_q <= '0;
      out_path_q  <= 1'b0;
      f_node_q    <= '0;
      f_flags_q   <= '0;
      cp_q        <= 1'b0;
      term_q      <= 1'b0;
      tok_cnt_q   <= '0;
      cp_cnt_q    <= '0;
      term_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= rdy_en_d;
      out_valid_q <= out_valid_d;
      out_node_q  <= out_node_d;
      out_flags_q <= out_flags_d;
      out_path_q  <= out_path_d;
      f_node_q    <= f_node_d;
      f_flags_q   <= f_flags_d;
      cp_q        <= cp_d;
      term_q      <= term_d;
      tok_cnt_q   <= tok_cnt_d;
      cp_cnt_q    <= cp_cnt_d;
      term_cnt_q  <= term_cnt_d;
    end
  end

endmodule

// File: tb/tb_dest_gen_pipe.sv
// Directed self-checking bench for dest_gen_pipe (overflow flagging enabled,
// 4-bit counters so saturation is reachable).
module tb_dest_gen_pipe;

  localparam int NODE_W = 16;
  localparam int OFS_W  = 8;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cnt_clr;
  logic             term_o;
  logic [CNT_W-1:0] tok_cnt, cp_cnt, term_cnt;

  int tests;
  int fails;

  always #5 clk = ~clk;

  dgp_if #(.NODE_W(NODE_W), .OFS_W(OFS_W)) bus ();

  dest_gen_pipe #(.NODE_W(NODE_W), .OFS_W(OFS_W), .OVF_MODE(1), .CNT_W(CNT_W)) dut (
    .clk_i_dgp      (clk),
    .rst_i_dgp      (rst),
    .bus            (bus),
    .term_o_dgp     (term_o),
    .cnt_clr_i_dgp  (cnt_clr),
    .tok_cnt_o_dgp  (tok_cnt),
    .cp_cnt_o_dgp   (cp_cnt),
    .term_cnt_o_dgp (term_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [15:0] node, input logic uni,
                            input logic lr, input logic path, input logic ovf);
    check({tag, "_valid"}, bus.out_valid_o_dgp, 1);
    check({tag, "_node"}, bus.out_node_o_dgp, node);
    check({tag, "_uni"}, bus.out_uni_opr_o_dgp, uni);
    check({tag, "_lr"}, bus.out_lr_o_dgp, lr);
    check({tag, "_path"}, bus.out_path_o_dgp, path);
    check({tag, "_ovf"}, bus.out_ovf_o_dgp, ovf);
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid_i_dgp      = 1'b0;
    bus.node_i_dgp          = '0;
    bus.t_dest_i_dgp        = '0;
    bus.f_dest_i_dgp        = '0;
    bus.t_uni_opr_i_dgp     = 1'b0;
    bus.t_lr_i_dgp          = 1'b0;
    bus.f_uni_opr_i_dgp     = 1'b0;
    bus.f_lr_i_dgp          = 1'b0;
    bus.cc_i_dgp            = 2'b00;
    bus.rslt_jmp_i_dgp      = 1'b0;
    bus.rslt_cc_i_dgp       = 2'b00;
    bus.cc_type_i_dgp       = 3'b000;
    bus.pe_out_i_dgp        = 1'b0;
    bus.pe_lr_i_dgp         = 1'b0;
    bus.jmp_dst_valid_i_dgp = 1'b0;
    bus.jmp_dst_i_dgp       = '0;
    bus.gate_i_dgp          = 1'b0;
    bus.out_ready_i_dgp     = 1'b1;
  endtask

  // Present the current token for exactly one accepting edge.
  task automatic send();
    bus.in_valid_i_dgp = 1'b1;
    tick();
    bus.in_valid_i_dgp = 1'b0;
  endtask

  task automatic copy_token();
    idle_in();
    bus.rslt_jmp_i_dgp  = 1'b1;
    bus.cc_i_dgp        = 2'b11;
    bus.node_i_dgp      = 16'h0100;
    bus.t_dest_i_dgp    = 8'h05;
    bus.f_dest_i_dgp    = 8'hFE;
    bus.t_lr_i_dgp      = 1'b1;
    bus.f_uni_opr_i_dgp = 1'b1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    cnt_clr = 1'b0;
    idle_in();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid_o_dgp, 0);
    check("rst_ready", bus.in_ready_o_dgp, 0);
    check("rst_node", bus.out_node_o_dgp, 0);
    check("rst_term", term_o, 0);
    check("rst_tok", tok_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", bus.in_ready_o_dgp, 1);
    check("post_rst_valid", bus.out_valid_o_dgp, 0);

    // Non-jump token: single T beat, latency 1
    bus.node_i_dgp      = 16'h0100;
    bus.t_dest_i_dgp    = 8'h05;
    bus.t_uni_opr_i_dgp = 1'b1;
    send();
    check_beat("a", 16'h0105, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("a_done", bus.out_valid_o_dgp, 0);
    check("a_tok", tok_cnt, 1);

    // Not-taken jump uses F offset and F flags; beat held while stalled
    idle_in();
    bus.rslt_jmp_i_dgp  = 1'b1;
    bus.cc_i_dgp        = 2'b01;
    bus.node_i_dgp      = 16'h0100;
    bus.t_dest_i_dgp    = 8'h05;
    bus.f_dest_i_dgp    = 8'hFE;
    bus.f_lr_i_dgp      = 1'b1;
    bus.f_uni_opr_i_dgp = 1'b1;
    bus.out_ready_i_dgp = 1'b0;
    send();
    check_beat("b", 16'h00FE, 1'b1, 1'b1, 1'b0, 1'b0);
    check("b_stall_ready", bus.in_ready_o_dgp, 0);
    tick();
    tick();
    check_beat("b_hold", 16'h00FE, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.out_ready_i_dgp = 1'b1;
    tick();
    check("b_done", bus.out_valid_o_dgp, 0);

    // Back-to-back non-copy tokens, one beat per cycle
    idle_in();
    bus.node_i_dgp     = 16'h0200;
    bus.t_dest_i_dgp   = 8'h10;
    bus.in_valid_i_dgp = 1'b1;
    tick();
    check_beat("c1", 16'h0210, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.node_i_dgp   = 16'h0300;
    bus.t_dest_i_dgp = 8'h7F;
    check("c_ready", bus.in_ready_o_dgp, 1);
    tick();
    bus.in_valid_i_dgp = 1'b0;
    check_beat("c2", 16'h037F, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("c_done", bus.out_valid_o_dgp, 0);
    check("c_tok", tok_cnt, 4);

    // Copy token: T beat then F beat on consecutive cycles
    copy_token();
    send();
    check_beat("d_t", 16'h0105, 1'b0, 1'b1, 1'b0, 1'b0);
    check("d_t_ready", bus.in_ready_o_dgp, 0);
    tick();
    check_beat("d_f", 16'h00FE, 1'b1, 1'b0, 1'b1, 1'b0);
    check("d_f_ready", bus.in_ready_o_dgp, 1);
    tick();
    check("d_done", bus.out_valid_o_dgp, 0);
    check("d_cp", cp_cnt, 1);

    // Failing gate terminates the token
    idle_in();
    bus.gate_i_dgp = 1'b1;
    send();
    check("e_valid", bus.out_valid_o_dgp, 0);
    check("e_term", term_o, 1);
    check("e_term_cnt", term_cnt, 1);
    tick();
    check("e_term_end", term_o, 0);

    // Jump with cc=11 and non-zero cc_type terminates
    idle_in();
    bus.rslt_jmp_i_dgp = 1'b1;
    bus.cc_i_dgp       = 2'b11;
    bus.cc_type_i_dgp  = 3'b001;
    send();
    check("f_valid", bus.out_valid_o_dgp, 0);
    check("f_term", term_o, 1);
    check("f_term_cnt", term_cnt, 2);
    tick();
    check("f_term_end", term_o, 0);

    // Positive overflow wraps and flags
    idle_in();
    bus.node_i_dgp   = 16'hFFFF;
    bus.t_dest_i_dgp = 8'h01;
    send();
    check_beat("g", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Absolute jump target never overflows
    bus.jmp_dst_valid_i_dgp = 1'b1;
    bus.jmp_dst_i_dgp       = 17'h1ABCD;
    send();
    check_beat("h", 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Negative result underflows and flags
    idle_in();
    bus.node_i_dgp   = 16'h0001;
    bus.t_dest_i_dgp = 8'hFE;
    send();
    check_beat("i", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // PE output overrides T-path LR
    idle_in();
    bus.node_i_dgp   = 16'h0010;
    bus.pe_out_i_dgp = 1'b1;
    bus.pe_lr_i_dgp  = 1'b1;
    send();
    check_beat("j", 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("j_tok", tok_cnt, 11);
    check("j_cp", cp_cnt, 1);
    check("j_term", term_cnt, 2);

    // Reset during a stalled copy drops the pending F beat
    copy_token();
    bus.out_ready_i_dgp = 1'b0;
    send();
    check_beat("k0", 16'h0105, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_beat("k1", 16'h0105, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_beat("k2", 16'h0105, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("k_rst_valid", bus.out_valid_o_dgp, 0);
    check("k_rst_node", bus.out_node_o_dgp, 0);
    check("k_rst_path", bus.out_path_o_dgp, 0);
    check("k_rst_tok", tok_cnt, 0);
    check("k_rst_cp", cp_cnt, 0);
    tick();
    rst = 1'b0;
    bus.out_ready_i_dgp = 1'b1;
    tick();
    check("k_ready", bus.in_ready_o_dgp, 1);
    check("k_valid", bus.out_valid_o_dgp, 0);
    tick();
    tick();
    check("k_no_f", bus.out_valid_o_dgp, 0);

    // Counter saturation and clear-over-increment
    idle_in();
    bus.node_i_dgp     = 16'h0100;
    bus.t_dest_i_dgp   = 8'h01;
    bus.in_valid_i_dgp = 1'b1;
    repeat (17) tick();
    check("l_sat", tok_cnt, 15);
    check_beat("l", 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    tick();
    check("l_clr", tok_cnt, 0);
    cnt_clr = 1'b0;
    tick();
    check("l_resume", tok_cnt, 1);
    bus.in_valid_i_dgp = 1'b0;
    tick();
    check("l_done", bus.out_valid_o_dgp, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
